// File: rtl/ff_bank_pkg.sv
// Shared encodings for the multimode flip-flop bank: runtime mode select
// and the build-time resolution of an SR-mode S=R=1 request.
package ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'd0,
        MODE_JK = 2'd1,
        MODE_D  = 2'd2,
        MODE_T  = 2'd3
    } mode_e;

    localparam int PRI_RESET = 0;
    localparam int PRI_SET   = 1;
    localparam int PRI_HOLD  = 2;

endpackage

// File: rtl/ff_bank_cell.sv
// One bit of the flip-flop bank: next-state selection for the four modes
// and SR conflict detection. Purely combinational; the top owns the flops.
module ff_bank_cell
    import ff_bank_pkg::*;
#(
    parameter int SR_PRIORITY = PRI_RESET
) (
    input  logic       i_q,
    input  logic       i_s,
    input  logic       i_r,
    input  logic       i_en,
    input  logic [1:0] i_mode,
    output logic       o_d,
    output logic       o_conflict
);

    logic w_sr_both;

    always_comb begin
        case (SR_PRIORITY)
            PRI_SET:  w_sr_both = 1'b1;
            PRI_HOLD: w_sr_both = i_q;
            default:  w_sr_both = 1'b0;
        endcase
    end

    always_comb begin
        o_d = i_q;
        if (i_en) begin
            case (mode_e'(i_mode))
                MODE_SR: begin
                    case ({i_s, i_r})
                        2'b01:   o_d = 1'b0;
                        2'b10:   o_d = 1'b1;
                        2'b11:   o_d = w_sr_both;
                        default: o_d = i_q;
                    endcase
                end
                MODE_JK: begin
                    case ({i_s, i_r})
                        2'b01:   o_d = 1'b0;
                        2'b10:   o_d = 1'b1;
                        2'b11:   o_d = ~i_q;
                        default: o_d = i_q;
                    endcase
                end
                MODE_D:  o_d = i_s;
                MODE_T:  o_d = i_q ^ i_s;
                default: o_d = i_q;
            endcase
        end
    end

    assign o_conflict = i_en & (i_mode == MODE_SR) & i_s & i_r;

endmodule

// File: rtl/ff_bank_multimode.sv
// WIDTH-bit flip-flop bank with runtime SR/JK/D/T mode, clock enable,
// synchronous reset to INIT, and SR-conflict mask / saturating count / sticky flag.
module ff_bank_multimode
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}},
    parameter int               SR_PRIORITY = PRI_RESET,
    parameter int               CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_s,
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_clr_flag,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_bar,
    output logic [WIDTH-1:0] o_conflict_mask,
    output logic [CNT_W-1:0] o_conflict_cnt,
    output logic             o_conflict_flag
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_conflict;
    logic             w_any;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_bank_cell #(
            .SR_PRIORITY(SR_PRIORITY)
        ) u_cell (
            .i_q       (r_q[i]),
            .i_s       (i_s[i]),
            .i_r       (i_r[i]),
            .i_en      (i_en),
            .i_mode    (i_mode),
            .o_d       (w_d[i]),
            .o_conflict(w_conflict[i])
        );
    end

    assign w_any = |w_conflict;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q    <= INIT;
            r_mask <= '0;
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            r_q    <= w_d;
            r_mask <= w_conflict;
            // A conflict in the same cycle as a clear restarts the count at 1.
            if (i_clr_flag && w_any) begin
                r_cnt  <= CNT_W'(1);
                r_flag <= 1'b1;
            end else if (i_clr_flag) begin
                r_cnt  <= '0;
                r_flag <= 1'b0;
            end else if (w_any) begin
                if (r_cnt != {CNT_W{1'b1}})
                    r_cnt <= r_cnt + CNT_W'(1);
                r_flag <= 1'b1;
            end
        end
    end

    assign o_q             = r_q;
    assign o_q_bar         = ~r_q;
    assign o_conflict_mask = r_mask;
    assign o_conflict_cnt  = r_cnt;
    assign o_conflict_flag = r_flag;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Scoreboard bench: three banks (SR_PRIORITY 0/1/2) share stimulus; a bench
// model pushes expected outputs per cycle, each test pops and compares.
module tb_ff_bank_multimode;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] qb;
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       flag;
    } out_t;

    localparam logic [3:0] INIT = 4'b1010;

    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic [1:0] mode;
    logic [3:0] s, r;

    logic [3:0] q0, q1, q2, qb0, qb1, qb2, m0, m1, m2;
    logic [2:0] c0, c1, c2;
    logic       f0, f1, f2;

    out_t [2:0] obs;
    out_t [2:0] ex;
    out_t [2:0] exq[$];

    logic [3:0] m_q[3];
    logic [2:0] m_cnt;
    logic       m_flag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ff_bank_multimode #(.WIDTH(4), .INIT(INIT), .SR_PRIORITY(0), .CNT_W(3)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_s(s), .i_r(r),
        .i_clr_flag(clr), .o_q(q0), .o_q_bar(qb0), .o_conflict_mask(m0),
        .o_conflict_cnt(c0), .o_conflict_flag(f0));
    ff_bank_multimode #(.WIDTH(4), .INIT(INIT), .SR_PRIORITY(1), .CNT_W(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_s(s), .i_r(r),
        .i_clr_flag(clr), .o_q(q1), .o_q_bar(qb1), .o_conflict_mask(m1),
        .o_conflict_cnt(c1), .o_conflict_flag(f1));
    ff_bank_multimode #(.WIDTH(4), .INIT(INIT), .SR_PRIORITY(2), .CNT_W(3)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_s(s), .i_r(r),
        .i_clr_flag(clr), .o_q(q2), .o_q_bar(qb2), .o_conflict_mask(m2),
        .o_conflict_cnt(c2), .o_conflict_flag(f2));

    assign obs[0] = {q0, qb0, m0, c0, f0};
    assign obs[1] = {q1, qb1, m1, c1, f1};
    assign obs[2] = {q2, qb2, m2, c2, f2};

    function automatic logic nb(logic q, logic sb, logic rb, logic [1:0] md, int pri);
        case (md)
            2'd0: case ({sb, rb})
                2'b01:   return 1'b0;
                2'b10:   return 1'b1;
                2'b11:   return (pri == 0) ? 1'b0 : (pri == 1) ? 1'b1 : q;
                default: return q;
            endcase
            2'd1: case ({sb, rb})
                2'b01:   return 1'b0;
                2'b10:   return 1'b1;
                2'b11:   return ~q;
                default: return q;
            endcase
            2'd2:    return sb;
            default: return sb ? ~q : q;
        endcase
    endfunction

    // Drive one cycle from a negedge, advance the model, queue expectations,
    // and return at the next negedge with the DUT outputs settled.
    task automatic cyc(input logic i_rst, input logic i_en, input logic [1:0] i_mode,
                       input logic [3:0] i_s, input logic [3:0] i_r, input logic i_clr);
        logic [3:0] mask;
        out_t [2:0] e;
        rst = i_rst; en = i_en; mode = i_mode; s = i_s; r = i_r; clr = i_clr;
        mask = (i_en && i_mode == 2'd0) ? (i_s & i_r) : 4'b0;
        if (i_rst) begin
            for (int k = 0; k < 3; k++) m_q[k] = INIT;
            m_cnt = 3'd0; m_flag = 1'b0; mask = 4'b0;
        end else begin
            if (i_en)
                for (int k = 0; k < 3; k++)
                    for (int b = 0; b < 4; b++)
                        m_q[k][b] = nb(m_q[k][b], i_s[b], i_r[b], i_mode, k);
            if (i_clr && mask != 0) begin m_cnt = 3'd1; m_flag = 1'b1; end
            else if (i_clr)         begin m_cnt = 3'd0; m_flag = 1'b0; end
            else if (mask != 0)     begin
                if (m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
                m_flag = 1'b1;
            end
        end
        for (int k = 0; k < 3; k++) e[k] = {m_q[k], ~m_q[k], mask, m_cnt, m_flag};
        exq.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1, 1, 2'd0, 4'hF, 4'h0, 0);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex) begin n_fail++; $display("FAIL reset: got %h want %h", obs, ex); end
        n_tests++;
        if ({q0, qb0, m0, c0, f0} !== {4'b1010, 4'b0101, 4'b0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_const: got %h want %h", obs[0], {4'b1010, 4'b0101, 8'h00});
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 2'd0, 4'hF, 4'hF, 1);
            ex = exq.pop_front(); n_tests++;
            if (obs !== ex) begin n_fail++; $display("FAIL reset_hold%0d: got %h want %h", i, obs, ex); end
        end
    endtask

    task automatic test_sr_table();
        cyc(1, 0, 2'd0, 4'h0, 4'h0, 0);
        void'(exq.pop_front());
        cyc(0, 1, 2'd0, 4'b0101, 4'b1001, 0);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex) begin n_fail++; $display("FAIL sr_table: got %h want %h", obs, ex); end
        n_tests++;
        if ({q0, q1, q2, m0, c0, f0} !== {4'b0110, 4'b0111, 4'b0110, 4'b0001, 3'd1, 1'b1}) begin
            n_fail++; $display("FAIL sr_priority: got q %b %b %b want 0110 0111 0110", q0, q1, q2);
        end
    endtask

    task automatic test_jk_t();
        cyc(1, 0, 2'd0, 4'h0, 4'h0, 0);
        void'(exq.pop_front());
        cyc(0, 1, 2'd1, 4'hF, 4'hF, 0);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex || q0 !== 4'b0101 || c0 !== 3'd0) begin
            n_fail++; $display("FAIL jk_toggle: got %h want %h", obs, ex);
        end
        cyc(0, 1, 2'd3, 4'b0011, 4'hF, 0);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex || q0 !== 4'b0110) begin
            n_fail++; $display("FAIL t_toggle: got %h want %h", obs, ex);
        end
    endtask

    task automatic test_d_en();
        cyc(1, 0, 2'd0, 4'h0, 4'h0, 0);
        void'(exq.pop_front());
        cyc(0, 0, 2'd2, 4'b1100, 4'h0, 0);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex || q0 !== 4'b1010) begin
            n_fail++; $display("FAIL d_en_low: got %h want %h", obs, ex);
        end
        cyc(0, 1, 2'd2, 4'b1100, 4'h0, 0);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex || q0 !== 4'b1100) begin
            n_fail++; $display("FAIL d_en_high: got %h want %h", obs, ex);
        end
    endtask

    task automatic test_saturation();
        cyc(1, 0, 2'd0, 4'h0, 4'h0, 0);
        void'(exq.pop_front());
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 2'd0, 4'b0001, 4'b0001, 0);
            ex = exq.pop_front(); n_tests++;
            if (obs !== ex || c0 !== ((i < 7) ? 3'(i + 1) : 3'd7) || f0 !== 1'b1) begin
                n_fail++; $display("FAIL sat%0d: got %h want %h", i, obs, ex);
            end
        end
    endtask

    task automatic test_clear();
        cyc(0, 1, 2'd0, 4'b0000, 4'b0000, 1);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex || c0 !== 3'd0 || f0 !== 1'b0) begin
            n_fail++; $display("FAIL clr_only: got %h want %h", obs, ex);
        end
        cyc(0, 1, 2'd0, 4'b0010, 4'b0010, 1);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex || c0 !== 3'd1 || f0 !== 1'b1) begin
            n_fail++; $display("FAIL clr_event: got %h want %h", obs, ex);
        end
        cyc(1, 1, 2'd0, 4'b0010, 4'b0010, 1);
        ex = exq.pop_front(); n_tests++;
        if (obs !== ex || {q0, m0, c0, f0} !== {INIT, 4'b0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL rst_clr_event: got %h want %h", obs, ex);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                ($urandom_range(0, 7) == 0));
            ex = exq.pop_front(); n_tests++;
            if (obs !== ex) begin n_fail++; $display("FAIL random%0d: got %h want %h", i, obs, ex); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'd0; s = '0; r = '0;
        m_cnt = '0; m_flag = 1'b0;
        for (int k = 0; k < 3; k++) m_q[k] = INIT;
        @(negedge clk);
        test_reset();
        test_sr_table();
        test_jk_t();
        test_d_en();
        test_saturation();
        test_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
